// File: rtl/edge_detection_pkg.sv
// Shared video timing constants, pixel type and timing-generator state encoding.
package edge_detection_pkg;

  // Default 640x480@60 timing (pixel clocks per line, lines per frame)
  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;
  localparam int unsigned V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // Counter and coordinate widths
  localparam int unsigned HW    = 10;
  localparam int unsigned VW    = 10;
  localparam int unsigned XW    = 10;
  localparam int unsigned YW    = 9;
  localparam int unsigned PIX_W = 24;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } vtg_state_t;

endpackage

// File: rtl/video_timing_gen.sv
// Raster timing generator: requests pixels from a frame source one cycle ahead
// and emits an aligned RGB/HSYNC/VSYNC/DE stream through a two-stage delay line.
module video_timing_gen
  import edge_detection_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic          pclk,
  input  logic          rst_n,
  input  logic          en,
  output logic          pix_req_c,
  output logic [XW-1:0] req_x,
  output logic [YW-1:0] req_y,
  input  pixel_t        src_data,
  input  logic          src_valid,
  output pixel_t        pix_data,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          frame_start,
  output logic          underflow
);

  localparam logic [HW-1:0] H_ACT_L  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_S = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_E = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST   = HW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [VW-1:0] V_ACT_L  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_S = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_E = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  vtg_state_t    state;
  logic [HW-1:0] h;
  logic [VW-1:0] v;

  logic running_c, active_c, hs_win_c, vs_win_c, frame_end_c, line_end_c;

  logic s1_de, s1_hs, s1_vs, s1_first;

  // Counter-derived raster decode for the current cycle
  always_comb begin
    running_c   = (state != ST_IDLE);
    active_c    = running_c && (h < H_ACT_L) && (v < V_ACT_L);
    hs_win_c    = running_c && (h >= H_SYNC_S) && (h < H_SYNC_E);
    vs_win_c    = running_c && (v >= V_SYNC_S) && (v < V_SYNC_E);
    line_end_c  = (h == H_LAST);
    frame_end_c = line_end_c && (v == V_LAST);
  end

  assign pix_req_c = active_c;
  assign req_x     = XW'(h);
  assign req_y     = YW'(v);

  // Run/drain FSM and raster counters; a frame always runs to completion once started
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      h     <= '0;
      v     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          h <= '0;
          v <= '0;
          if (en) state <= ST_RUN;
        end
        default: begin
          if (frame_end_c) begin
            h     <= '0;
            v     <= '0;
            state <= en ? ST_RUN : ST_IDLE;
          end else begin
            if (line_end_c) begin
              h <= '0;
              v <= v + VW'(1);
            end else begin
              h <= h + HW'(1);
            end
            state <= en ? ST_RUN : ST_DRAIN;
          end
        end
      endcase
    end
  end

  // Stage 1: hold timing flags while the source fetches the requested pixel
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      s1_de    <= 1'b0;
      s1_hs    <= 1'b0;
      s1_vs    <= 1'b0;
      s1_first <= 1'b0;
    end else begin
      s1_de    <= active_c;
      s1_hs    <= hs_win_c;
      s1_vs    <= vs_win_c;
      s1_first <= active_c && (h == '0) && (v == '0);
    end
  end

  // Stage 2: output stream aligned with returned pixel data, plus sticky underflow
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      de          <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      frame_start <= 1'b0;
      pix_data    <= '0;
      underflow   <= 1'b0;
    end else begin
      de          <= s1_de;
      hsync       <= s1_hs ? SYNC_POL : ~SYNC_POL;
      vsync       <= s1_vs ? SYNC_POL : ~SYNC_POL;
      frame_start <= s1_first;
      pix_data    <= (s1_de && src_valid) ? src_data : '0;
      underflow   <= (s1_de && !src_valid) || (underflow && !s1_first);
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench for video_timing_gen using a reduced raster geometry.
module tb_video_timing_gen;

  localparam int HA = 16, HF = 2, HS = 3, HB = 4;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        src_valid = 1'b0;
  logic [23:0] src_data = '0;
  logic        pix_req;
  logic [9:0]  req_x;
  logic [8:0]  req_y;
  logic [23:0] pix_data;
  logic        hsync, vsync, de, frame_start, underflow;

  int n_assert = 0;
  int n_fail   = 0;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0)
  ) dut (
    .pclk(clk), .rst_n(rst_n), .en(en),
    .pix_req_c(pix_req), .req_x(req_x), .req_y(req_y),
    .src_data(src_data), .src_valid(src_valid),
    .pix_data(pix_data), .hsync(hsync), .vsync(vsync), .de(de),
    .frame_start(frame_start), .underflow(underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // Reference model: frame position as a single index, raster coordinates by arithmetic
  bit          m_act;
  int          m_pos;
  bit          p_req, p_first, p_hs, p_vs;
  bit          e_de, e_fs, e_hs, e_vs, e_under;
  logic [23:0] e_data;
  bit          drv_req;
  int          drv_x, drv_y;
  int          drop_x = -1, drop_y = -1, drop_pct = 0;

  // Measurement state
  int cyc = 0, first_req = -1, first_de = -1, last_fs = -1, period = -1;
  int de_cnt = 0, hs_low = 0, vs_low = 0, f_de = 0, f_hs = 0, f_vs = 0;
  bit last_under = 0, under_pre_fs = 0;

  function automatic int mx(); return m_pos % HT; endfunction
  function automatic int my(); return m_pos / HT; endfunction
  function automatic bit m_req(); return m_act && mx() < HA && my() < VA; endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_pos = 0;
    p_req = 0; p_first = 0; p_hs = 0; p_vs = 0;
    e_de = 0; e_fs = 0; e_hs = 0; e_vs = 0; e_under = 0; e_data = '0;
    drv_req = 0;
  endtask

  task automatic model_edge();
    bit c_req, c_hs, c_vs, c_first;
    c_req   = m_req();
    c_hs    = m_act && mx() >= HA + HF && mx() < HA + HF + HS;
    c_vs    = m_act && my() >= VA + VF && my() < VA + VF + VS;
    c_first = c_req && m_pos == 0;
    e_de    = p_req;
    e_fs    = p_first;
    e_hs    = p_hs;
    e_vs    = p_vs;
    e_data  = (p_req && src_valid) ? src_data : 24'h0;
    e_under = (p_req && !src_valid) || (e_under && !p_first);
    p_req = c_req; p_hs = c_hs; p_vs = c_vs; p_first = c_first;
    if (m_act) begin
      if (m_pos == FRAME - 1) begin m_pos = 0; m_act = en; end
      else m_pos++;
    end else if (en) begin
      m_act = 1; m_pos = 0;
    end
  endtask

  task automatic check_outputs();
    chk("pix_req", 32'(pix_req), 32'(m_req()));
    if (m_req()) begin
      chk("req_x", 32'(req_x), 32'(mx()));
      chk("req_y", 32'(req_y), 32'(my()));
    end
    chk("de", 32'(de), 32'(e_de));
    chk("frame_start", 32'(frame_start), 32'(e_fs));
    chk("hsync", 32'(hsync), 32'(!e_hs));
    chk("vsync", 32'(vsync), 32'(!e_vs));
    chk("pix_data", 32'(pix_data), 32'(e_data));
    chk("underflow", 32'(underflow), 32'(e_under));
  endtask

  // Frame source: answers last cycle's request, sometimes withholds it, sometimes strays
  task automatic drive_source();
    bit drop;
    if (drv_req) begin
      drop = (drv_x == drop_x && drv_y == drop_y) || ($urandom_range(99) < 32'(drop_pct));
      src_valid = !drop;
      src_data  = drop ? 24'($urandom()) : {8'(drv_x), 8'(drv_y), 8'h5A};
    end else begin
      src_valid = ($urandom_range(9) == 0);
      src_data  = 24'($urandom());
    end
    drv_req = m_req();
    drv_x   = mx();
    drv_y   = my();
  endtask

  task automatic stats();
    if (pix_req && first_req < 0) first_req = cyc;
    if (de && first_de < 0) first_de = cyc;
    if (frame_start) begin
      if (last_fs >= 0) period = cyc - last_fs;
      last_fs = cyc;
      f_de = de_cnt; f_hs = hs_low; f_vs = vs_low;
      de_cnt = 0; hs_low = 0; vs_low = 0;
      under_pre_fs = last_under;
    end
    de_cnt += int'(de);
    hs_low += int'(!hsync);
    vs_low += int'(!vsync);
    last_under = underflow;
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset(); else model_edge();
    @(negedge clk);
    cyc++;
    check_outputs();
    stats();
    drive_source();
  endtask

  task automatic wait_fs(input int limit, input string tag);
    bit got = 0;
    for (int k = 0; k < limit && !got; k++) begin
      step();
      got = frame_start;
    end
    chk(tag, 32'(got), 32'd1);
  endtask

  task automatic run_until(input int tx, input int ty, input int limit, input string tag);
    bit got;
    got = m_act && mx() == tx && my() == ty;
    for (int k = 0; k < limit && !got; k++) begin
      step();
      got = m_act && mx() == tx && my() == ty;
    end
    chk(tag, 32'(got), 32'd1);
  endtask

  initial begin
    int req_cnt;
    bit got;
    model_reset();
    // Reset values held while rst_n is low
    repeat (3) step();
    chk("rst_de", 32'(de), 32'd0);
    chk("rst_hsync", 32'(hsync), 32'd1);
    chk("rst_vsync", 32'(vsync), 32'd1);
    chk("rst_pix_req", 32'(pix_req), 32'd0);
    rst_n = 1'b1;
    repeat (3) step();

    // First frame with a missing pixel at (5,3)
    drop_x = 5; drop_y = 3;
    en = 1'b1;
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin step(); got = de; end
    chk("first_de_seen", 32'(got), 32'd1);
    chk("req_to_de_latency", 32'(first_de - first_req), 32'd2);
    chk("first_pixel", 32'(pix_data), 32'h00005A);
    chk("first_frame_start", 32'(frame_start), 32'd1);

    wait_fs(FRAME + 5, "frame2_start");
    drop_x = -1; drop_y = -1;
    chk("frame_period", 32'(period), 32'(FRAME));
    chk("de_per_frame", 32'(f_de), 32'(HA * VA));
    chk("hsync_low_cycles", 32'(f_hs), 32'(HS * VT));
    chk("vsync_low_cycles", 32'(f_vs), 32'(VS * HT));
    chk("underflow_before_fs", 32'(under_pre_fs), 32'd1);
    chk("underflow_cleared_at_fs", 32'(underflow), 32'd0);

    // Drop en mid-frame: frame completes, then idle with no requests
    run_until(0, 4, FRAME, "reach_line4");
    en = 1'b0;
    got = 0;
    for (int k = 0; k < 2 * FRAME && !got; k++) begin step(); got = !m_act; end
    chk("drain_to_idle", 32'(got), 32'd1);
    req_cnt = 0;
    repeat (6) begin step(); req_cnt += int'(pix_req); end
    chk("idle_no_requests", 32'(req_cnt), 32'd0);
    chk("drained_frame_de", 32'(de_cnt), 32'(HA * VA));

    // Re-enable during drain: back-to-back frames without a gap
    en = 1'b1;
    wait_fs(10, "restart_fs");
    run_until(0, 2, FRAME, "reach_line2");
    en = 1'b0;
    run_until(0, 5, FRAME, "reach_line5");
    en = 1'b1;
    wait_fs(FRAME + 5, "cont_fs1");
    chk("cont_period1", 32'(period), 32'(FRAME));
    wait_fs(FRAME + 5, "cont_fs2");
    chk("cont_period2", 32'(period), 32'(FRAME));

    // Randomized enable toggling and source drops against the model
    drop_pct = 5;
    repeat (3000) begin
      if ($urandom_range(99) == 0) en = !en;
      step();
    end
    drop_pct = 0;

    // Reset asserted mid-frame aborts immediately
    en = 1'b1;
    run_until(8, 4, 2 * FRAME + 10, "reach_mid_frame");
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    chk("abort_pix_req", 32'(pix_req), 32'd0);
    chk("abort_de", 32'(de), 32'd0);
    chk("abort_pix_data", 32'(pix_data), 32'd0);
    chk("abort_frame_start", 32'(frame_start), 32'd0);
    chk("abort_underflow", 32'(underflow), 32'd0);
    chk("abort_hsync", 32'(hsync), 32'd1);
    chk("abort_vsync", 32'(vsync), 32'd1);
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
    de_cnt = 0;
    repeat (20) step();
    chk("no_de_after_reset", 32'(de_cnt), 32'd0);
    en = 1'b1;
    repeat (30) step();
    chk("restart_after_reset_de", 32'(de_cnt > 0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
